imem_ctrl: RTL and testbench
============================

# imem_ctrl

Controller for the synchronous, single-ported instruction RAM of the 5-stage pipelined RISC-V core. It owns the RAM port. After reset it runs a boot-load phase that streams program words into the RAM. It then shares the read port between the IF stage and a debug read requester, with a starvation guard. All RAM accesses use word indexing derived from byte addresses.

## Interface
- DEPTH, 64: RAM depth in 32-bit words; power of two.
- AW, $clog2(DEPTH): RAM word-address width.
- STARVE_MAX, 4: consecutive cycles debug may lose arbitration before it is forced a grant; range 1..15.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks final loader word.
- ld_ready  out  1  loader word accepted this cycle when high with ld_valid.
- boot_done  out  1  high once load phase has completed.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address.
- if_stall  out  1  fetch not granted this cycle.
- if_valid  out  1  if_inst valid (response to previous-cycle grant).
- if_inst  out  32  fetched instruction.
- dbg_req  in  1  debug read request; held until granted.
- dbg_addr  in  32  debug byte address.
- dbg_ack  out  1  dbg_rdata valid (response to previous-cycle grant).
- dbg_rdata  out  32  debug read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid 1 cycle after mem_en with mem_we=0.

## Operation
- FSM states: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - ld_ready = 1 (0 while rst).
  - On ld_valid: mem_en=1, mem_we=1, mem_addr=wptr, mem_wdata=ld_data, wptr++.
  - Go to RUN on an accepted word with ld_last=1, or on an accepted write at wptr=DEPTH-1 (whichever comes first).
  - Fetch and debug requests are stalled: if_stall=if_req; no dbg grant.
- RUN:
  - ld_ready=0; ld_valid is ignored; boot_done=1.
  - At most one read grant per cycle.
  - Fetch has priority, except when starve_cnt==STARVE_MAX and dbg_req=1; then debug wins.
  - starve_cnt increments each cycle dbg_req=1 and not granted. It clears on dbg grant or when dbg_req=0.
- Address mapping: word index = addr[AW+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH.
- A registered owner tag (NONE/IF/DBG) routes mem_rdata next cycle to if_inst+if_valid or dbg_rdata+dbg_ack.
- if_inst and dbg_rdata hold their last value when not valid.

## Timing
- Reset values: state=LOAD, wptr=0, starve_cnt=0, owner=NONE, boot_done=0, if_valid=0, dbg_ack=0, if_inst=0, dbg_rdata=0.
- While rst is high: mem_en=0, mem_we=0, ld_ready=0.
- Read latency: grant in cycle N gives if_valid or dbg_ack in cycle N+1.
- Back-to-back grants give one response per cycle.
- if_stall is combinational in the same cycle as the request.
- boot_done rises the cycle after the final load write.
- The first fetch grant is possible in that same cycle.
- Reset asserted mid-load or mid-read: in-flight response dropped, wptr cleared, RAM contents untouched, state LOAD.
- Simultaneous if_req and dbg_req below the threshold: IF granted, dbg not acked.

## Configuration
- IMEM_ALIGN_CHECK_EN defined:
  - Adds output if_fault (1 bit, reset 0), registered alongside if_valid.
  - if_fault=1 when the granted if_addr[1:0]!=0 or if_addr[31:AW+2]!=0.
  - if_inst is still driven from the wrapped word address.
- Undefined: no if_fault port; misaligned or out-of-range addresses silently wrap.

## Structure
- Shared package imem_pkg:
  - state enum {LOAD, RUN}.
  - owner enum {OWN_NONE, OWN_IF, OWN_DBG}.
  - WORD_W=32.
  - byte-to-word address function.
- One sub-module: imem_rd_arb. It holds the fetch/debug priority logic and starve_cnt, and outputs grant_if/grant_dbg.
- The top module holds the FSM, load pointer, owner tag and response routing.

## Test plan
- Load words 0xA, 0xB, 0xC with ld_last on the third: expect RAM writes at 0,1,2 and boot_done=1 next cycle. Then fetch at if_addr=0x8: expect if_valid=1 and if_inst=0xC one cycle later.
- Stream 70 words with no ld_last (DEPTH=64): expect 64 writes, RUN after word 63, and ld_ready=0 for the remaining 6.
- Hold if_req and dbg_req continuously with STARVE_MAX=4: expect debug granted in RUN cycle 5 (if_stall=1 that cycle) and dbg_ack in cycle 6. Fetch then regains 4 cycles before the next forced grant.
- Assert rst after 10 loaded words with an in-flight stall pending: expect state LOAD, wptr=0, boot_done=0, if_valid=0. Reload then overwrites from address 0.
- if_addr=0x100 with DEPTH=64: expect word 0 returned. With IMEM_ALIGN_CHECK_EN also expect if_fault=1. With if_addr=0x6 and the macro defined, expect if_fault=1 and word 1 returned.
- If_req during LOAD: if_stall=1 every cycle, no mem read, and if_valid stays 0 until RUN.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction RAM controller.
package imem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {LOAD, RUN} state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DBG} owner_t;

  // Byte address to word index; callers keep the low AW bits, so addresses wrap.
  function automatic logic [WORD_W-1:0] byte_to_word(input logic [WORD_W-1:0] addr);
    return {2'b00, addr[WORD_W-1:2]};
  endfunction

endpackage

// File: rtl/imem_rd_arb.sv
// Fetch/debug read arbiter: fetch wins unless debug has waited STARVE_MAX cycles.
module imem_rd_arb
  import imem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic dbg_req,
  output logic grant_if,
  output logic grant_dbg
);

  logic [3:0] starve_cnt;
  logic       force_dbg;

  always_comb begin
    force_dbg = en && dbg_req && (starve_cnt == 4'(STARVE_MAX));
    grant_dbg = en && dbg_req && (!if_req || force_dbg);
    grant_if  = en && if_req && !force_dbg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!en || !dbg_req || grant_dbg) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction RAM controller: boot-load phase, then arbitrated fetch/debug reads.
// Optional IMEM_ALIGN_CHECK_EN adds an if_fault output for misaligned/out-of-range fetches.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              boot_done,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_inst,
  input  logic              dbg_req,
  input  logic [WORD_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [WORD_W-1:0] dbg_rdata,
`ifdef IMEM_ALIGN_CHECK_EN
  output logic              if_fault,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  state_t            state;
  owner_t            owner;
  logic [AW-1:0]     wptr;
  logic [WORD_W-1:0] if_hold;
  logic [WORD_W-1:0] dbg_hold;
  logic [WORD_W-1:0] if_word;
  logic [WORD_W-1:0] dbg_word;
  logic              grant_if;
  logic              grant_dbg;
  logic              unused_bits;

  assign if_word     = byte_to_word(if_addr);
  assign dbg_word    = byte_to_word(dbg_addr);
  assign unused_bits = ^{if_word[WORD_W-1:AW], dbg_word[WORD_W-1:AW]};

  imem_rd_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (state == RUN),
    .if_req   (if_req),
    .dbg_req  (dbg_req),
    .grant_if (grant_if),
    .grant_dbg(grant_dbg)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_ready  = 1'b0;
    if_stall  = if_req;
    if (!rst) begin
      if (state == LOAD) begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wptr;
          mem_wdata = ld_data;
        end
      end else begin
        mem_en   = grant_if || grant_dbg;
        if_stall = if_req && !grant_if;
        if (grant_if) begin
          mem_addr = if_word[AW-1:0];
        end else if (grant_dbg) begin
          mem_addr = dbg_word[AW-1:0];
        end
      end
    end
  end

  // RAM data arrives in the cycle after the grant, so responses bypass mem_rdata
  // through the owner tag and the hold registers keep the last value otherwise.
  assign if_valid  = (owner == OWN_IF);
  assign dbg_ack   = (owner == OWN_DBG);
  assign if_inst   = if_valid ? mem_rdata : if_hold;
  assign dbg_rdata = dbg_ack ? mem_rdata : dbg_hold;

`ifdef IMEM_ALIGN_CHECK_EN
  logic [WORD_W-1:0] if_addr_hi;
  logic              misaligned;

  assign if_addr_hi = if_addr >> (AW + 2);
  assign misaligned = (if_addr[1:0] != 2'b00) || (if_addr_hi != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_fault <= 1'b0;
    end else begin
      if_fault <= grant_if && misaligned;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      wptr      <= '0;
      owner     <= OWN_NONE;
      boot_done <= 1'b0;
      if_hold   <= '0;
      dbg_hold  <= '0;
    end else begin
      if (grant_if) begin
        owner <= OWN_IF;
      end else if (grant_dbg) begin
        owner <= OWN_DBG;
      end else begin
        owner <= OWN_NONE;
      end
      if (owner == OWN_IF) begin
        if_hold <= mem_rdata;
      end
      if (owner == OWN_DBG) begin
        dbg_hold <= mem_rdata;
      end
      if (state == LOAD && ld_valid) begin
        wptr <= wptr + 1'b1;
        if (ld_last || wptr == AW'(DEPTH - 1)) begin
          state     <= RUN;
          boot_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed self-checking bench for imem_ctrl with a behavioural RAM.
// Checks if_fault as well when IMEM_ALIGN_CHECK_EN is defined.
module tb_imem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          boot_done;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_stall;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic          dbg_req;
  logic [31:0]   dbg_addr;
  logic          dbg_ack;
  logic [31:0]   dbg_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
`ifdef IMEM_ALIGN_CHECK_EN
  logic          if_fault;
`endif

  logic [31:0] ram [DEPTH];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_ctrl #(
    .DEPTH(DEPTH),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .boot_done(boot_done),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_stall (if_stall),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_ack  (dbg_ack),
    .dbg_rdata(dbg_rdata),
`ifdef IMEM_ALIGN_CHECK_EN
    .if_fault (if_fault),
`endif
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_dbg, prev_if, prev_dbg;

  initial begin
    rst = 1'b1; ld_valid = 1'b1; ld_data = 32'h1; ld_last = 1'b0;
    if_req = 1'b0; if_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
    tick(); #1;
    check("rst_ld_ready", ld_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);

    // Three-word boot load with fetch requests pending throughout
    for (int i = 0; i < 3; i++) begin
      tick();
      rst = 1'b0; ld_valid = 1'b1; ld_data = 32'hA + i; ld_last = (i == 2);
      if_req = 1'b1; if_addr = '0;
      #1;
      check("load_ready", ld_ready, 1);
      check("load_we", mem_we, 1);
      check("load_addr", mem_addr, i);
      check("load_wdata", mem_wdata, 32'hA + i);
      check("load_if_stall", if_stall, 1);
      check("load_if_valid", if_valid, 0);
      check("load_boot_done", boot_done, 0);
    end
    tick();
    ld_valid = 1'b1; ld_data = 32'hDEAD; ld_last = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    #1;
    check("run_boot_done", boot_done, 1);
    check("run_ld_ready", ld_ready, 0);
    check("run_if_stall", if_stall, 0);
    check("run_mem_we", mem_we, 0);
    check("run_mem_addr", mem_addr, 2);
    check("run_if_valid0", if_valid, 0);
    tick();
    ld_valid = 1'b0; if_addr = 32'h100;
    #1;
    check("fetch8_valid", if_valid, 1);
    check("fetch8_inst", if_inst, 32'hC);
    check("wrap_mem_addr", mem_addr, 0);
`ifdef IMEM_ALIGN_CHECK_EN
    check("fetch8_fault", if_fault, 0);
`endif
    tick();
    if_addr = 32'h6;
    #1;
    check("wrap_valid", if_valid, 1);
    check("wrap_inst", if_inst, 32'hA);
    check("mis_mem_addr", mem_addr, 1);
`ifdef IMEM_ALIGN_CHECK_EN
    check("wrap_fault", if_fault, 1);
`endif
    tick();
    if_req = 1'b0;
    #1;
    check("mis_inst", if_inst, 32'hB);
`ifdef IMEM_ALIGN_CHECK_EN
    check("mis_fault", if_fault, 1);
`endif
    tick(); #1;
    check("idle_valid", if_valid, 0);
    check("idle_inst_hold", if_inst, 32'hB);

    // Continuous fetch + debug requests: debug forced on 5th and 10th cycle
    prev_if = 1'b0; prev_dbg = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if_req = 1'b1; if_addr = 32'h0; dbg_req = 1'b1; dbg_addr = 32'h4;
      #1;
      exp_dbg = (k == 5) || (k == 10);
      check("starve_if_stall", if_stall, exp_dbg);
      check("starve_mem_addr", mem_addr, exp_dbg ? 1 : 0);
      check("starve_dbg_ack", dbg_ack, prev_dbg);
      check("starve_if_valid", if_valid, prev_if);
      if (prev_dbg) check("starve_dbg_rdata", dbg_rdata, 32'hB);
      if (prev_if)  check("starve_if_inst", if_inst, 32'hA);
      prev_if = !exp_dbg; prev_dbg = exp_dbg;
    end
    tick();
    if_req = 1'b0; dbg_req = 1'b0;
    #1;
    check("post_dbg_ack", dbg_ack, 0);
    check("post_if_valid", if_valid, 1);
    check("post_dbg_hold", dbg_rdata, 32'hB);

    // Reset with a read in flight drops the response
    tick();
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    check("inflight_grant", if_stall, 0);
    tick();
    if_req = 1'b0; rst = 1'b1;
    #1;
    check("inflight_dropped", if_valid, 0);
    check("inflight_boot_done", boot_done, 0);
    check("inflight_ld_ready", ld_ready, 0);
    check("inflight_if_inst", if_inst, 0);

    // Partial reload of ten words, then reset mid-load
    for (int i = 0; i < 10; i++) begin
      tick();
      rst = 1'b0; ld_valid = 1'b1; ld_data = 32'h100 + i; if_req = 1'b1;
      #1;
      check("part_addr", mem_addr, i);
      check("part_stall", if_stall, 1);
    end
    tick();
    rst = 1'b1; ld_valid = 1'b0; if_req = 1'b0;
    #1;
    check("part_rst_boot_done", boot_done, 0);
    check("part_rst_valid", if_valid, 0);
    tick();
    rst = 1'b0;

    // 70 words without ld_last: only 64 accepted
    for (int i = 0; i < 70; i++) begin
      tick();
      ld_valid = 1'b1; ld_data = 32'h200 + i;
      #1;
      if (i < 64) begin
        check("full_addr", mem_addr, i);
        check("full_ready", ld_ready, 1);
        check("full_we", mem_we, 1);
        check("full_boot_done", boot_done, 0);
      end else begin
        check("full_ready_off", ld_ready, 0);
        check("full_mem_en_off", mem_en, 0);
        check("full_boot_done_on", boot_done, 1);
      end
    end
    tick();
    ld_valid = 1'b0; if_req = 1'b1; if_addr = 32'hFC;
    #1;
    tick();
    if_addr = 32'h0;
    #1;
    check("full_last_word", if_inst, 32'h23F);
    tick();
    if_req = 1'b0;
    #1;
    check("full_first_word", if_inst, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
